regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive lost ALU arbitrations before the ALU is forced to win; legal range 1-15.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_valid  input  1  ALU result offered.
REQ-005 alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result value.
REQ-008 mem_valid  input  1  load result offered.
REQ-009 mem_ready  output  1  load result accepted this cycle when mem_valid is also high.
REQ-010 mem_rd  input  5  load destination register.
REQ-011 mem_data  input  32  load result value.
REQ-012 issue_valid  input  1  instruction issued that will write issue_rd.
REQ-013 issue_rd  input  5  destination of the issued instruction.
REQ-014 write_enable  output  1  register-file write strobe, registered.
REQ-015 rd  output  5  register-file write address, registered.
REQ-016 write_data  output  32  register-file write data, registered.
REQ-017 busy  output  32  scoreboard; bit n high means a write to xn is pending.

Function
REQ-018 The block SHALL grant at most one source per cycle; a transfer occurs when valid and ready are both high.
REQ-019 Default priority SHALL be mem over ALU: mem_ready = !force_alu; alu_ready = force_alu || !mem_valid.
REQ-020 force_alu SHALL be high when starve_cnt >= STARVE_LIMIT and alu_valid is high.
REQ-021 starve_cnt (4 bits) SHALL increment, saturating at 15, each cycle alu_valid is high and alu_ready is low; it SHALL clear to 0 on any cycle the ALU transfers or alu_valid is low.
REQ-022 Ready outputs SHALL be combinational from valid inputs and starve_cnt, with no dependence on data or rd inputs.
REQ-023 On a transfer with a nonzero source rd, the block SHALL, on the next posedge, drive write_enable=1, rd=source rd, and write_data=source data, giving 1-cycle latency.
REQ-024 A transfer with rd==0 SHALL be accepted and discarded: write_enable=0 next cycle and no busy change.
REQ-025 With no transfer, write_enable SHALL be 0 next cycle; rd and write_data SHALL hold their previous values.
REQ-026 On issue_valid with issue_rd!=0, busy[issue_rd] SHALL be set on the next posedge.
REQ-027 When the registered write_enable is high, busy[rd] SHALL clear on the next posedge.
REQ-028 If a set and a clear target the same bit in the same cycle, set SHALL win.
REQ-029 busy[0] SHALL be constant 0.
REQ-030 Producers SHALL hold valid, rd, and data stable until accepted; the block does not check this.

Reset
REQ-031 While reset is high, write_enable, rd, write_data, busy, and starve_cnt SHALL be 0 on the next posedge; reset SHALL override transfers and issues in the same cycle.
REQ-032 Transfers offered in the reset cycle SHALL be discarded; ready outputs SHALL remain combinational during reset.

Verification
REQ-033 Reset, then ALU only: alu_rd=5, alu_data=0x1234 -> alu_ready=1 same cycle; next cycle write_enable=1, rd=5, write_data=0x1234.
REQ-034 Simultaneous offers: mem_rd=3 with 0xAAAA, alu_rd=4 with 0xBBBB -> mem wins (write rd=3); ALU is written the cycle after mem_valid drops.
REQ-035 Starvation: mem_valid held high, alu_valid high, STARVE_LIMIT=4 -> ALU loses 4 cycles; 5th cycle alu_ready=1, mem_ready=0; starve_cnt returns to 0.
REQ-036 Scoreboard: issue x7 -> busy[7]=1; an ALU write to x7 clears it one cycle after write_enable; issue x7 in the same cycle as the write_enable for x7 -> busy[7] stays 1.
REQ-037 x0 handling: issue_rd=0 and mem_rd=0 transfer -> busy stays 0 and write_enable stays 0.
REQ-038 Mid-operation reset: reset asserted in the cycle after a transfer, with busy=0x00000080 -> next cycle write_enable=0 and busy=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: picks the load or the ALU result, registers one
// write per cycle, and keeps a busy scoreboard of destinations with pending writes.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        write_enable,
    output logic [4:0]  rd,
    output logic [31:0] write_data,
    output logic [31:0] busy
);

    // Handshake: a source transfers in a cycle where its valid and ready are both
    // high; ready is combinational from the valids and the starvation counter only.

    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [31:0] busy_q, busy_d;

    logic        force_alu;
    logic        alu_xfer;
    logic        mem_xfer;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    assign force_alu = alu_valid && (starve_cnt_q >= 4'(STARVE_LIMIT));
    assign mem_ready = !force_alu;
    assign alu_ready = force_alu || !mem_valid;
    assign mem_xfer  = mem_valid && mem_ready;
    assign alu_xfer  = alu_valid && alu_ready;

    assign sel_rd    = mem_xfer ? mem_rd   : alu_rd;
    assign sel_data  = mem_xfer ? mem_data : alu_data;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!alu_valid || alu_xfer) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Writes to x0 are accepted but dropped; rd/data hold when nothing is written.
    always_comb begin
        we_d   = (mem_xfer || alu_xfer) && (sel_rd != 5'd0);
        rd_d   = rd_q;
        data_d = data_q;
        if (we_d) begin
            rd_d   = sel_rd;
            data_d = sel_data;
        end
    end

    // Clear first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
            we_q         <= 1'b0;
            rd_q         <= 5'd0;
            data_q       <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
        end
    end

    assign write_enable = we_q;
    assign rd           = rd_q;
    assign write_data   = data_q;
    assign busy         = busy_q;

endmodule
